ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, the instruction queue depth in entries (legal values 2..8).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port mem_cs  output  1  memory read request (chip select).
REQ-006 The module SHALL have port mem_addr  output  32  word-aligned fetch address.
REQ-007 The module SHALL have port mem_rdata  input  32  instruction word returned by memory.
REQ-008 The module SHALL have port mem_ready  input  1  memory response valid; may be high in the same cycle as mem_cs.
REQ-009 The module SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-010 The module SHALL have port inst  output  32  instruction word at queue head.
REQ-011 The module SHALL have port inst_pc  output  32  address of inst.
REQ-012 The module SHALL have port inst_ready  input  1  consumer accepts head this cycle.
REQ-013 The module SHALL have port redirect  input  1  flush and restart fetch.
REQ-014 The module SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored.

Function
REQ-015 FSM states SHALL be FETCH (request may be issued) and FULL (queue full, no request).
REQ-016 mem_cs SHALL be 1 iff state==FETCH, count<DEPTH and redirect==0; mem_cs SHALL have no combinational path from inst_ready.
REQ-017 mem_addr SHALL equal the fetch_pc register, with bits [1:0] always 0.
REQ-018 A transfer SHALL occur on a rising edge with mem_cs&&mem_ready: push {mem_rdata, fetch_pc} at queue tail; fetch_pc <= fetch_pc+4.
REQ-019 mem_cs&&!mem_ready SHALL hold mem_addr stable; nothing is pushed; no wait limit.
REQ-020 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 inst_valid SHALL equal (count!=0); inst and inst_pc SHALL come from queue storage (registered), not from mem_rdata.
REQ-022 A pop SHALL occur on an edge with inst_valid&&inst_ready; push and pop in the same cycle SHALL leave count unchanged, sustaining one instruction per cycle.
REQ-023 Push SHALL never occur when count==DEPTH; pop SHALL never occur when count==0; order SHALL be strictly FIFO.
REQ-024 FETCH->FULL when count becomes DEPTH; FULL->FETCH when count drops below DEPTH.
REQ-025 On an edge with redirect==1: queue count <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}, state <= FETCH; any same-cycle pop has no additional effect.
REQ-026 The first request at the new address SHALL be issued the cycle after redirect (1-cycle bubble); redirect held high SHALL keep mem_cs low and the queue empty.

Reset
REQ-027 While rst_n==0: fetch_pc=RESET_PC, count=0, state=FETCH, mem_cs=0, inst_valid=0, inst=0, inst_pc=0.
REQ-028 Reset assertion SHALL take effect immediately mid-transfer, discarding any pending request and all queued entries.
REQ-029 In the first cycle after rst_n rises: mem_cs=1, mem_addr=RESET_PC.

Verification
REQ-030 Reset release, mem_ready tied 1, memory word0=32'h10001137, word1=32'hff000337, inst_ready=1 -> inst_valid from cycle 2, inst_pc 0x0,0x4,0x8... one per cycle, inst matching memory.
REQ-031 inst_ready=0 for 6 cycles -> exactly DEPTH (2) entries held, mem_cs=0 in state FULL, mem_addr=0x8; inst_ready=1 -> 0x0,0x4 popped in order, fetching resumes at 0x8.
REQ-032 mem_ready low 3 cycles with mem_cs=1, mem_addr=0x10 -> mem_addr stable at 0x10, no push; ready high -> one push, next mem_addr=0x14.
REQ-033 redirect=1, redirect_pc=32'h0000_0022 with 2 queued entries -> next cycle inst_valid=0, mem_cs=1, mem_addr=0x20; first delivered inst_pc=0x20.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
REQ-035 rst_n dropped mid-stream with 1 entry queued -> inst_valid and mem_cs 0 immediately; after release, mem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: sequential word fetcher feeding a small FIFO.
// Redirect flushes the queue and restarts fetching at a new word-aligned address.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_cs,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
   localparam logic [PW-1:0] L_LAST  = PW'(DEPTH - 1);

   typedef enum logic {S_FETCH, S_FULL} state_t;

   state_t          r_state;
   logic [31:0]     r_fetch_pc;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [31:0]     r_q_inst [DEPTH];
   logic [31:0]     r_q_pc   [DEPTH];

   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_count_nxt;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == L_LAST) ? '0 : p + 1'b1;
   endfunction

   // Gated by rst_n so no request is visible while reset is held.
   assign mem_cs     = rst_n && (r_state == S_FETCH) && (r_count < L_DEPTH) && !redirect;
   assign mem_addr   = {r_fetch_pc[31:2], 2'b00};
   assign inst_valid = (r_count != '0);
   assign inst       = r_q_inst[r_head];
   assign inst_pc    = r_q_pc[r_head];

   assign w_push = mem_cs && mem_ready;
   assign w_pop  = inst_valid && inst_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_inst[i] <= '0;
            r_q_pc[i]   <= '0;
         end
      end else if (redirect) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         if (w_push) begin
            r_q_inst[r_tail] <= mem_rdata;
            r_q_pc[r_tail]   <= mem_addr;
            r_tail           <= next_ptr(r_tail);
            r_fetch_pc       <= mem_addr + 32'd4;
         end
         if (w_pop) begin
            r_head <= next_ptr(r_head);
         end
         r_count <= w_count_nxt;
         r_state <= (w_count_nxt == L_DEPTH) ? S_FULL : S_FETCH;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch.
// A second instance with a high reset address covers address wrap.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_cs, mem_cs1;
   logic [31:0] mem_addr, mem_addr1;
   logic [31:0] mem_rdata, mem_rdata1;
   logic        mem_ready;
   logic        inst_valid, inst_valid1;
   logic [31:0] inst, inst1, inst_pc, inst_pc1;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        one = 1'b1;
   logic        zero = 1'b0;
   logic [31:0] zero32 = 32'h0;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h1000_1137;
         32'h0000_0004: return 32'hff00_0337;
         default:       return {a[15:0] ^ 16'h5A5A, a[31:16]};
      endcase
   endfunction

   assign mem_rdata  = mem_word(mem_addr);
   assign mem_rdata1 = mem_word(mem_addr1);

   ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_cs(mem_cs), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .mem_cs(mem_cs1), .mem_addr(mem_addr1),
      .mem_rdata(mem_rdata1), .mem_ready(one), .inst_valid(inst_valid1),
      .inst(inst1), .inst_pc(inst_pc1), .inst_ready(one),
      .redirect(zero), .redirect_pc(zero32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; inst_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0;
      step(); step();
      #1;
      chk("rst_mem_cs",     {31'b0, mem_cs}, 32'd0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst",       inst, 32'h0);
      chk("rst_inst_pc",    inst_pc, 32'h0);
      chk("rst_mem_addr",   mem_addr, 32'h0);

      // streaming from reset, one instruction per cycle
      rst_n = 1'b1;
      #1;
      chk("c1_mem_cs",   {31'b0, mem_cs}, 32'd1);
      chk("c1_mem_addr", mem_addr, 32'h0);
      chk("c1_valid",    {31'b0, inst_valid}, 32'd0);
      chk("w_c1_addr",   mem_addr1, 32'hFFFF_FFF8);
      step(); #1;
      chk("c2_valid",    {31'b0, inst_valid}, 32'd1);
      chk("c2_pc",       inst_pc, 32'h0);
      chk("c2_inst",     inst, 32'h1000_1137);
      chk("c2_addr",     mem_addr, 32'h4);
      chk("w_c2_pc",     inst_pc1, 32'hFFFF_FFF8);
      chk("w_c2_addr",   mem_addr1, 32'hFFFF_FFFC);
      step(); #1;
      chk("c3_pc",       inst_pc, 32'h4);
      chk("c3_inst",     inst, 32'hff00_0337);
      chk("w_c3_pc",     inst_pc1, 32'hFFFF_FFFC);
      chk("w_c3_addr",   mem_addr1, 32'h0);
      step(); #1;
      chk("c4_pc",       inst_pc, 32'h8);
      chk("c4_inst",     inst, mem_word(32'h8));
      chk("w_c4_pc",     inst_pc1, 32'h0);
      chk("w_c4_inst",   inst1, 32'h1000_1137);

      // backpressure: queue fills to DEPTH and fetching stops
      rst_n = 1'b0; inst_ready = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      #1;
      chk("full_valid",  {31'b0, inst_valid}, 32'd1);
      chk("full_pc",     inst_pc, 32'h0);
      chk("full_cs",     {31'b0, mem_cs}, 32'd0);
      chk("full_addr",   mem_addr, 32'h8);
      inst_ready = 1'b1;
      #1;
      chk("full_cs_ready", {31'b0, mem_cs}, 32'd0);
      step(); #1;
      chk("drain_pc4",   inst_pc, 32'h4);
      chk("drain_cs",    {31'b0, mem_cs}, 32'd1);
      chk("drain_addr",  mem_addr, 32'h8);
      step(); #1;
      chk("resume_pc8",  inst_pc, 32'h8);
      step(); #1;
      chk("resume_pcC",  inst_pc, 32'hC);
      chk("resume_addr", mem_addr, 32'h10);

      // memory wait states
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("wait_addr",  mem_addr, 32'h10);
         chk("wait_cs",    {31'b0, mem_cs}, 32'd1);
         chk("wait_valid", {31'b0, inst_valid}, 32'd0);
      end
      mem_ready = 1'b1;
      step(); #1;
      chk("wait_push_pc",   inst_pc, 32'h10);
      chk("wait_push_inst", inst, mem_word(32'h10));
      chk("wait_next_addr", mem_addr, 32'h14);

      // redirect with two queued entries
      inst_ready = 1'b0;
      step(); #1;
      chk("pre_redir_cs", {31'b0, mem_cs}, 32'd0);
      redirect = 1'b1; redirect_pc = 32'h0000_0022;
      step();
      redirect = 1'b0;
      #1;
      chk("redir_valid", {31'b0, inst_valid}, 32'd0);
      chk("redir_cs",    {31'b0, mem_cs}, 32'd1);
      chk("redir_addr",  mem_addr, 32'h20);
      inst_ready = 1'b1;
      step(); #1;
      chk("redir_pc",    inst_pc, 32'h20);
      chk("redir_inst",  inst, mem_word(32'h20));

      // redirect held high keeps fetch idle
      redirect = 1'b1; redirect_pc = 32'h0000_0041;
      step(); step(); #1;
      chk("hold_cs",    {31'b0, mem_cs}, 32'd0);
      chk("hold_valid", {31'b0, inst_valid}, 32'd0);
      redirect = 1'b0;
      #1;
      chk("hold_addr",  mem_addr, 32'h40);

      // asynchronous reset with one entry queued
      inst_ready = 1'b0;
      step(); #1;
      chk("one_q_valid", {31'b0, inst_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, inst_valid}, 32'd0);
      chk("arst_cs",    {31'b0, mem_cs}, 32'd0);
      chk("arst_inst",  inst, 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      chk("rel_addr",   mem_addr, 32'h0);
      chk("rel_cs",     {31'b0, mem_cs}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
